// File: rtl/d_flip_flop_async_clr.sv
// ---------------------------------------------------------------------------
// d_flip_flop_async_clr
//   Single D flip-flop with asynchronous, active-high clear. One instance
//   forms one stage of the ripple counter.
//
// Ports
//   D   : input,  1 bit, data captured on the rising edge of Clk
//   Clk : input,  1 bit, stage clock (rising-edge active)
//   Clr : input,  1 bit, asynchronous active-high clear; forces Q to 0
//   Q   : output, 1 bit, stored value
// ---------------------------------------------------------------------------
module d_flip_flop_async_clr (
    input  logic D,
    input  logic Clk,
    input  logic Clr,
    output logic Q
);

    // Stage storage: clear dominates, otherwise capture D on the clock edge.
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            Q <= 1'b0;
        end else begin
            Q <= D;
        end
    end

endmodule

// File: rtl/counter_dflipflop_with_async_clk_up_4bit.sv
// ---------------------------------------------------------------------------
// counter_dflipflop_with_async_clk_up_4bit
//   Ripple (asynchronous-clock) binary up counter made of WIDTH toggling
//   D flip-flops. Only stage 0 sees Clk; every later stage is clocked by the
//   inverted output of the stage before it, so a stage toggles when its
//   predecessor falls from 1 to 0 -- the carry of an up count.
//
//   The bits of count settle one after another as the carry ripples, so
//   count passes through transient values after each Clk edge. count must
//   NOT be used as a synchronous signal in the Clk domain (or any other
//   clock domain) without proper resynchronisation.
//
//   Clr is applied to every stage directly with no synchroniser; aligning
//   its release with Clk is the integrator's responsibility.
//
// Parameters
//   WIDTH : number of counter stages (minimum 1), default 4
//
// Ports (positional order: count, Clk, Clr)
//   count : output, WIDTH bits, flip-flop Q outputs
//   Clk   : input,  1 bit, counter clock, count advances on its rising edge
//   Clr   : input,  1 bit, asynchronous active-high clear, count forced to 0
// ---------------------------------------------------------------------------
module counter_dflipflop_with_async_clk_up_4bit #(
    parameter int WIDTH = 4
) (
    output logic [WIDTH-1:0] count,
    input  logic             Clk,
    input  logic             Clr
);

    logic [WIDTH-1:0] q_s;          // stage outputs
    logic [WIDTH-1:0] stage_clk_s;  // per-stage clock nets

    // Stage 0 runs from the counter clock; later stages from ~Q of the previous one.
    assign stage_clk_s[0] = Clk;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i = i + 1) begin : g_stage
            if (i > 0) begin : g_ripple_clk
                // Rising edge of ~Q[i-1] == falling edge of Q[i-1] == carry out.
                assign stage_clk_s[i] = ~q_s[i-1];
            end

            // Each stage feeds back its own complement so it toggles per clock.
            d_flip_flop_async_clr u_dff (
                .D   (~q_s[i]),
                .Clk (stage_clk_s[i]),
                .Clr (Clr),
                .Q   (q_s[i])
            );
        end
    endgenerate

    assign count = q_s;

endmodule

// File: tb/tb_counter_dflipflop_with_async_clk_up_4bit.sv
// ---------------------------------------------------------------------------
// tb_counter_dflipflop_with_async_clk_up_4bit
//   Directed bench for the ripple up counter: a WIDTH=4 instance on a 40 ns
//   free-running clock (first rise at 20 ns) and a WIDTH=2 instance driven
//   by hand-toggled clock edges.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_counter_dflipflop_with_async_clk_up_4bit;

    logic       clk;
    logic       clr;
    logic [3:0] count4;

    logic       clk2;
    logic       clr2;
    logic [1:0] count2;

    int vectors;
    int miscompares;

    counter_dflipflop_with_async_clk_up_4bit #(.WIDTH(4)) u_dut4 (
        .count (count4),
        .Clk   (clk),
        .Clr   (clr)
    );

    counter_dflipflop_with_async_clk_up_4bit #(.WIDTH(2)) u_dut2 (
        .count (count2),
        .Clk   (clk2),
        .Clr   (clr2)
    );

    // 40 ns period, first rising edge at 20 ns.
    initial begin
        clk = 1'b0;
        forever #20 clk = ~clk;
    end

    // Clr high from 0 to 45 ns; the rising edge at 20 ns must be ignored.
    task automatic test_reset();
        clr = 1'b1;
        #5;
        vectors++;
        if (count4 !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_t5: got %b expected %b", count4, 4'b0000);
        end
        #16; // 21 ns, just after the ignored edge
        vectors++;
        if (count4 !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_hold_edge20: got %b expected %b", count4, 4'b0000);
        end
        #23; // 44 ns
        vectors++;
        if (count4 !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_t44: got %b expected %b", count4, 4'b0000);
        end
        #1;  // 45 ns
        clr = 1'b0;
    endtask

    // After release: 1 at 60 ns, +1 every 40 ns, wrap 15->0 at 660 ns, 9 at 1020 ns.
    task automatic test_first_count_and_wrap();
        logic [3:0] exp_v;
        for (int n = 1; n <= 25; n++) begin
            @(posedge clk);
            #1;
            exp_v = 4'(n);
            vectors++;
            if (count4 !== exp_v) begin
                miscompares++;
                $display("FAIL count_edge_t%0t: got %b expected %b", $time, count4, exp_v);
            end
        end
    endtask

    // Falling edges of Clk leave count untouched (count is 9 here).
    task automatic test_falling_edge();
        @(negedge clk);
        #1;
        vectors++;
        if (count4 !== 4'b1001) begin
            miscompares++;
            $display("FAIL falling_edge: got %b expected %b", count4, 4'b1001);
        end
    endtask

    // Run from 9 up to 7 (14 edges through a wrap), then pulse Clr mid-count.
    task automatic test_midcount_reset();
        logic [3:0] exp_v;
        exp_v = 4'b1001;
        for (int n = 0; n < 14; n++) begin
            @(posedge clk);
            #1;
            exp_v = exp_v + 4'd1;
            vectors++;
            if (count4 !== exp_v) begin
                miscompares++;
                $display("FAIL midcount_run: got %b expected %b", count4, exp_v);
            end
        end
        #10;
        clr = 1'b1;
        #1;
        vectors++;
        if (count4 !== 4'b0000) begin
            miscompares++;
            $display("FAIL midcount_clear: got %b expected %b", count4, 4'b0000);
        end
        #4;
        clr = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if (count4 !== 4'b0001) begin
            miscompares++;
            $display("FAIL midcount_release: got %b expected %b", count4, 4'b0001);
        end
    endtask

    // Worst-case ripples: 0111->1000 and 1111->0000, all four bits change.
    task automatic test_ripple();
        logic [3:0] prev_v;
        repeat (6) @(posedge clk);
        #1;
        vectors++;
        if (count4 !== 4'b0111) begin
            miscompares++;
            $display("FAIL ripple_pre7: got %b expected %b", count4, 4'b0111);
        end
        prev_v = count4;
        @(posedge clk);
        #1;
        vectors++;
        if (count4 !== 4'b1000 || (prev_v ^ count4) !== 4'b1111) begin
            miscompares++;
            $display("FAIL ripple_7to8: got %b from %b expected %b", count4, prev_v, 4'b1000);
        end
        repeat (7) @(posedge clk);
        #1;
        prev_v = count4;
        vectors++;
        if (prev_v !== 4'b1111) begin
            miscompares++;
            $display("FAIL ripple_pre15: got %b expected %b", prev_v, 4'b1111);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (count4 !== 4'b0000 || (prev_v ^ count4) !== 4'b1111) begin
            miscompares++;
            $display("FAIL ripple_wrap: got %b from %b expected %b", count4, prev_v, 4'b0000);
        end
    endtask

    // Clr rising together with a Clk rising edge: Clr wins, count stays 0.
    task automatic test_coincident();
        @(posedge clk); // count -> 1
        @(negedge clk);
        #20;            // lands on the next rising edge
        clr = 1'b1;
        #1;
        vectors++;
        if (count4 !== 4'b0000) begin
            miscompares++;
            $display("FAIL coincident_clr: got %b expected %b", count4, 4'b0000);
        end
        #4;
        clr = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if (count4 !== 4'b0001) begin
            miscompares++;
            $display("FAIL coincident_release: got %b expected %b", count4, 4'b0001);
        end
    endtask

    // WIDTH=2: 0, 1, 2, 3, 0 on successive rising edges.
    task automatic test_width2();
        logic [1:0] exp_tab [0:4];
        exp_tab[0] = 2'd1;
        exp_tab[1] = 2'd2;
        exp_tab[2] = 2'd3;
        exp_tab[3] = 2'd0;
        exp_tab[4] = 2'd1;
        clk2 = 1'b0;
        clr2 = 1'b1;
        #2;
        clk2 = 1'b1; // ignored under clear
        #2;
        clk2 = 1'b0;
        #1;
        vectors++;
        if (count2 !== 2'd0) begin
            miscompares++;
            $display("FAIL w2_reset: got %b expected %b", count2, 2'd0);
        end
        clr2 = 1'b0;
        #2;
        for (int n = 0; n < 5; n++) begin
            clk2 = 1'b1;
            #1;
            vectors++;
            if (count2 !== exp_tab[n]) begin
                miscompares++;
                $display("FAIL w2_edge%0d: got %b expected %b", n, count2, exp_tab[n]);
            end
            #2;
            clk2 = 1'b0;
            #3;
        end
    endtask

    // Scenario sequence and summary.
    initial begin
        vectors     = 0;
        miscompares = 0;
        clr         = 1'b1;
        clk2        = 1'b0;
        clr2        = 1'b1;
        test_reset();
        test_first_count_and_wrap();
        test_falling_edge();
        test_midcount_reset();
        test_ripple();
        test_coincident();
        test_width2();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/counter_dflipflop_with_async_clk_up_4bit.md
COUNTER_DFLIPFLOP_WITH_ASYNC_CLK_UP_4BIT -- requirements
Module: counter_dflipflop_with_async_clk_up_4bit

Interface
REQ-001 The parameter list SHALL be: WIDTH, default 4, number of counter stages (minimum 1).
REQ-002 Port Clk SHALL be: input, 1 bit, counter clock; the count advances on its rising edge.
REQ-003 Port Clr SHALL be: input, 1 bit, reset; asynchronous and active-high; while 1, count is forced to 0.
REQ-004 Port count SHALL be: output, WIDTH bits, current count value, driven directly from the flip-flop Q outputs.
REQ-005 Positional port order SHALL be count, Clk, Clr, so that instantiations of the form (count, Clk, Clr) bind correctly.

Function
REQ-006 The block SHALL be a ripple (asynchronous-clock) binary up counter built from WIDTH D flip-flops; only stage 0 is clocked by Clk.
REQ-007 Each stage i SHALL have D = ~Q[i], so it toggles on every active edge of its own clock.
REQ-008 Stage 0 SHALL be clocked by the rising edge of Clk.
REQ-009 Stage i > 0 SHALL be clocked by the rising edge of ~Q[i-1], i.e. the falling edge of Q[i-1]; this gives up-counting.
REQ-010 After ripple settling, count SHALL equal (previous count + 1) mod 2^WIDTH after each rising edge of Clk while Clr = 0.
REQ-011 Wrap-around SHALL occur from 4'b1111 to 4'b0000 on a single Clk rising edge, with no extra state and no terminal-count hold.
REQ-012 Transient intermediate values during ripple propagation SHALL be permitted; the RTL SHALL contain no explicit # delays, so zero-delay simulation settles within the same time step.
REQ-013 Falling edges of Clk SHALL have no effect on count.
REQ-014 The count output SHALL NOT be used as a synchronous clock-domain signal; this restriction SHALL be documented in the module header comment.

Reset
REQ-015 Clr = 1 SHALL clear every stage to 0 immediately, independent of Clk, including during a ripple in progress.
REQ-016 While Clr = 1, Clk edges SHALL be ignored and count SHALL hold at 0.
REQ-017 After Clr falls to 0, the first rising edge of Clk SHALL produce count = 1.
REQ-018 A Clr edge coincident with a Clk rising edge SHALL resolve in favour of Clr, leaving count = 0.
REQ-019 There SHALL be no reset synchroniser; release timing SHALL be the integrator's responsibility.

Structure
REQ-020 No shared package SHALL be created; WIDTH SHALL remain a local parameter of the block.
REQ-021 A sub-module d_flip_flop_async_clr (inputs D, Clk, Clr; output Q, plus optional QN) SHALL be instantiated WIDTH times via a generate loop.
REQ-022 Inter-stage clocks SHALL be explicit wires taken from the QN or ~Q of the preceding stage.

Verification
REQ-023 Reset hold: Clk period 40 ns (first rise at 20 ns), Clr = 1 from 0 to 45 ns -> count = 0000 throughout, with the rising edge at 20 ns ignored.
REQ-024 First count: Clr falls at 45 ns -> count = 0001 at 60 ns, 0010 at 100 ns, then +1 every 40 ns.
REQ-025 Wrap: continuing the REQ-024 stimulus -> count = 1111 at 620 ns, 0000 at 660 ns, 0001 at 700 ns; at 1020 ns count = 1001.
REQ-026 Mid-count reset: pulse Clr = 1 for 5 ns while count = 0111 -> count = 0000 immediately, then 0001 on the next Clk rising edge after release.
REQ-027 Ripple worst case: the transition 0111 -> 1000 and the wrap 1111 -> 0000 -> final settled value correct in the same time step, with every bit having toggled exactly once.
REQ-028 Parameter check: WIDTH = 2 -> sequence 0, 1, 2, 3, 0 on successive Clk rising edges.
